wash_program_sequencer: RTL
===========================

Name: wash_program_sequencer

Overview:
- Parametrised washing-machine program controller with internal phase timers, a programmable number of rinse repeats, pause, and a fill-timeout fault.
- Sits between the debounced front-panel inputs and the LED/actuator drivers.
- Replaces the single-pass FSM and its external phase timers.

Parameters:
CNT_W, 16, width of phase duration counters and config inputs
RPT_W, 3, width of rinse-repeat count
FILL_TIMEOUT, 1000, max cycles in FILL without water_full before FAULT (must fit CNT_W)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start_n  in  1  active-low start request, level-sensitive, sampled in IDLE only
stop_n  in  1  active-low abort, level-sensitive, all states
pause  in  1  active-high hold
water_full  in  1  high = drum at target level
cfg_rinse_t  in  CNT_W  RINSE duration, cycles
cfg_drain_t  in  CNT_W  DRAIN duration, cycles
cfg_dehyd_t  in  CNT_W  DEHYD duration, cycles
cfg_alarm_t  in  CNT_W  DONE alarm duration, cycles
cfg_repeats  in  RPT_W  number of FILL-RINSE-DRAIN passes
state  out  3  current state code
led_n  out  7  active-low one-hot: bit0 IDLE, 1 FILL, 2 RINSE, 3 DRAIN, 4 DEHYD, 5 DONE, 6 FAULT
passes_left  out  RPT_W  remaining passes, including the current one
phase_done  out  1  one-cycle pulse on timed-phase exit
busy  out  1  high in FILL/RINSE/DRAIN/DEHYD

Behaviour:
- Reset (async, rst low): state=IDLE, led_n=7'b1111110, passes_left=0, phase_done=0, busy=0, all counters 0.
- State codes: IDLE 000, FILL 001, RINSE 011, DRAIN 010, DEHYD 110, DONE 100, FAULT 101.
- All outputs are registered and update on the same edge as state. led_n always matches the decoded state.
- Priority per cycle: stop_n low > fill timeout > pause > normal progression.
- stop_n low in any state other than IDLE: next state IDLE. Counters cleared, passes_left=0, no phase_done.
- IDLE:
  - start_n low and stop_n high -> FILL.
  - On that edge, latch all cfg_* inputs. A zero duration is latched as 1; cfg_repeats=0 is latched as 1.
  - passes_left = latched repeats.
  - Changing cfg_* inputs mid-program has no effect.
- FILL:
  - water_full high -> RINSE.
  - Otherwise the fill counter increments. When it reaches FILL_TIMEOUT -> FAULT.
  - Fill counter resets on each FILL entry.
- RINSE, DRAIN, DEHYD, DONE:
  - Down-counter is loaded with the latched duration N on entry.
  - Exactly N cycles are spent in the state: entered at edge t, exits at edge t+N.
- RINSE -> DRAIN.
- DRAIN:
  - passes_left>1 -> FILL, with passes_left decremented on the same edge.
  - passes_left==1 -> DEHYD, with passes_left set to 0.
- DEHYD -> DONE. DONE -> IDLE.
- FAULT: held until stop_n low, then -> IDLE. start_n is ignored.
- pause high in FILL/RINSE/DRAIN/DEHYD freezes the state, down-counter and fill counter. It is ignored in IDLE/DONE/FAULT.
- pause does not block stop_n.
- phase_done is high for the single cycle after each timer-expiry exit from RINSE, DRAIN, DEHYD and DONE. It is not asserted for FILL exit, abort or fault.
- start_n held low through DONE->IDLE restarts the program on the next edge, with cfg re-latched.

Test Plan:
- Reset then full run: cfg_rinse_t=4, cfg_drain_t=3, cfg_dehyd_t=5, cfg_alarm_t=2, cfg_repeats=1. Pulse start_n; water_full rises 2 cycles after FILL entry. Required: states 001, 011 (4 cycles), 010 (3), 110 (5), 100 (2), then 000. Exactly 4 phase_done pulses; led_n one-hot-low every cycle.
- cfg_repeats=3: FILL/RINSE/DRAIN occurs 3 times; passes_left reads 3, 2, 1 then 0 on DEHYD entry.
- Pause: raise pause for 10 cycles mid-RINSE with 2 of 4 cycles elapsed. Required: RINSE lasts 14 cycles total, led_n=7'b1111011 throughout.
- Fill timeout with FILL_TIMEOUT=8 and water_full held low. Required: FAULT after 8 cycles in FILL, led_n=7'b0111111. start_n is ignored; stop_n low returns to IDLE next edge.
- Abort: stop_n low during DEHYD. Required: IDLE next edge, passes_left=0, no phase_done. Asserting rst mid-DRAIN gives immediate reset values without waiting for a clock edge.
- Zero config: all durations 0 and repeats 0. Required: each timed state lasts 1 cycle and a single pass is executed.

Source files
------------

// File: rtl/wash_program_sequencer.sv
// Washing-machine program controller: FILL -> RINSE -> DRAIN passes repeated a
// configurable number of times, then DEHYD and a DONE alarm. Phase timers are
// internal and run from durations latched at program start. Supports pause,
// abort (stop_n) and a fill-timeout fault.
//
// Inputs are plain levels; there is no valid/ready handshake. start_n is
// sampled in IDLE only, stop_n in every state. All outputs are registered and
// change on the same clock edge as the state.
module wash_program_sequencer #(
    parameter int CNT_W        = 16,
    parameter int RPT_W        = 3,
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_n,
    input  logic             stop_n,
    input  logic             pause,
    input  logic             water_full,
    input  logic [CNT_W-1:0] cfg_rinse_t,
    input  logic [CNT_W-1:0] cfg_drain_t,
    input  logic [CNT_W-1:0] cfg_dehyd_t,
    input  logic [CNT_W-1:0] cfg_alarm_t,
    input  logic [RPT_W-1:0] cfg_repeats,
    output logic [2:0]       state,
    output logic [6:0]       led_n,
    output logic [RPT_W-1:0] passes_left,
    output logic             phase_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FILL  = 3'b001,
        ST_RINSE = 3'b011,
        ST_DRAIN = 3'b010,
        ST_DEHYD = 3'b110,
        ST_DONE  = 3'b100,
        ST_FAULT = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = '0;
    localparam logic [RPT_W-1:0] ONE_R     = RPT_W'(1);
    localparam logic [RPT_W-1:0] ZERO_R    = '0;
    // Last fill-count value before timeout; hitting it with the drum still
    // not full means FILL_TIMEOUT cycles have been spent in FILL.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

    // Active-low one-hot LED pattern for a state.
    function automatic logic [6:0] led_decode(input state_t s);
        logic [6:0] onehot;
        onehot = 7'b0000000;
        unique case (s)
            ST_IDLE:  onehot = 7'b0000001;
            ST_FILL:  onehot = 7'b0000010;
            ST_RINSE: onehot = 7'b0000100;
            ST_DRAIN: onehot = 7'b0001000;
            ST_DEHYD: onehot = 7'b0010000;
            ST_DONE:  onehot = 7'b0100000;
            ST_FAULT: onehot = 7'b1000000;
            default:  onehot = 7'b0000000;
        endcase
        return ~onehot;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_FILL) || (s == ST_RINSE) || (s == ST_DRAIN) || (s == ST_DEHYD);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [RPT_W-1:0] r_passes;
    logic [CNT_W-1:0] r_rinse_t;
    logic [CNT_W-1:0] r_drain_t;
    logic [CNT_W-1:0] r_dehyd_t;
    logic [CNT_W-1:0] r_alarm_t;
    logic             r_phase_done;
    logic [6:0]       r_led_n;
    logic             r_busy;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_fill_cnt;
    logic [RPT_W-1:0] w_passes;
    logic             w_phase_done;
    logic             w_latch;

    // Zero durations/repeats are treated as one so every phase takes >= 1 cycle.
    logic [CNT_W-1:0] w_rinse_sat;
    logic [CNT_W-1:0] w_drain_sat;
    logic [CNT_W-1:0] w_dehyd_sat;
    logic [CNT_W-1:0] w_alarm_sat;
    logic [RPT_W-1:0] w_rep_sat;

    assign w_rinse_sat = (cfg_rinse_t == ZERO_C) ? ONE_C : cfg_rinse_t;
    assign w_drain_sat = (cfg_drain_t == ZERO_C) ? ONE_C : cfg_drain_t;
    assign w_dehyd_sat = (cfg_dehyd_t == ZERO_C) ? ONE_C : cfg_dehyd_t;
    assign w_alarm_sat = (cfg_alarm_t == ZERO_C) ? ONE_C : cfg_alarm_t;
    assign w_rep_sat   = (cfg_repeats == ZERO_R) ? ONE_R : cfg_repeats;

    // Next-state, counter and pulse logic; priority is abort, fill timeout,
    // pause, then normal phase progression.
    always_comb begin
        w_next_state = r_state;
        w_cnt        = r_cnt;
        w_fill_cnt   = r_fill_cnt;
        w_passes     = r_passes;
        w_phase_done = 1'b0;
        w_latch      = 1'b0;

        if (!stop_n && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_cnt        = ZERO_C;
            w_fill_cnt   = ZERO_C;
            w_passes     = ZERO_R;
        end else if ((r_state == ST_FILL) && !water_full && (r_fill_cnt == FILL_LAST)) begin
            w_next_state = ST_FAULT;
            w_fill_cnt   = ZERO_C;
        end else if (pause && is_busy(r_state)) begin
            // Hold everything exactly as it is.
            w_next_state = r_state;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!start_n && stop_n) begin
                        w_next_state = ST_FILL;
                        w_latch      = 1'b1;
                        w_passes     = w_rep_sat;
                        w_fill_cnt   = ZERO_C;
                        w_cnt        = ZERO_C;
                    end
                end
                ST_FILL: begin
                    if (water_full) begin
                        w_next_state = ST_RINSE;
                        w_cnt        = r_rinse_t;
                        w_fill_cnt   = ZERO_C;
                    end else begin
                        w_fill_cnt = r_fill_cnt + ONE_C;
                    end
                end
                ST_RINSE: begin
                    if (r_cnt == ONE_C) begin
                        w_next_state = ST_DRAIN;
                        w_cnt        = r_drain_t;
                        w_phase_done = 1'b1;
                    end else begin
                        w_cnt = r_cnt - ONE_C;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == ONE_C) begin
                        w_phase_done = 1'b1;
                        if (r_passes > ONE_R) begin
                            w_next_state = ST_FILL;
                            w_passes     = r_passes - ONE_R;
                            w_cnt        = ZERO_C;
                            w_fill_cnt   = ZERO_C;
                        end else begin
                            w_next_state = ST_DEHYD;
                            w_passes     = ZERO_R;
                            w_cnt        = r_dehyd_t;
                        end
                    end else begin
                        w_cnt = r_cnt - ONE_C;
                    end
                end
                ST_DEHYD: begin
                    if (r_cnt == ONE_C) begin
                        w_next_state = ST_DONE;
                        w_cnt        = r_alarm_t;
                        w_phase_done = 1'b1;
                    end else begin
                        w_cnt = r_cnt - ONE_C;
                    end
                end
                ST_DONE: begin
                    if (r_cnt == ONE_C) begin
                        w_next_state = ST_IDLE;
                        w_cnt        = ZERO_C;
                        w_phase_done = 1'b1;
                    end else begin
                        w_cnt = r_cnt - ONE_C;
                    end
                end
                ST_FAULT: begin
                    // Only stop_n (handled above) leaves FAULT.
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_cnt        = ZERO_C;
                    w_fill_cnt   = ZERO_C;
                    w_passes     = ZERO_R;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= ZERO_C;
            r_fill_cnt   <= ZERO_C;
            r_passes     <= ZERO_R;
            r_phase_done <= 1'b0;
            r_led_n      <= 7'b1111110;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt;
            r_fill_cnt   <= w_fill_cnt;
            r_passes     <= w_passes;
            r_phase_done <= w_phase_done;
            r_led_n      <= led_decode(w_next_state);
            r_busy       <= is_busy(w_next_state);
        end
    end

    // Program configuration, captured only on the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rinse_t <= ZERO_C;
            r_drain_t <= ZERO_C;
            r_dehyd_t <= ZERO_C;
            r_alarm_t <= ZERO_C;
        end else if (w_latch) begin
            r_rinse_t <= w_rinse_sat;
            r_drain_t <= w_drain_sat;
            r_dehyd_t <= w_dehyd_sat;
            r_alarm_t <= w_alarm_sat;
        end
    end

    assign state       = r_state;
    assign led_n       = r_led_n;
    assign passes_left = r_passes;
    assign phase_done  = r_phase_done;
    assign busy        = r_busy;

endmodule
